// File: rtl/mult_job_scheduler.sv
// Job FIFO feeding an external sequential multiplier, with a held output register.
// Define MULT_JOB_SCHEDULER_TIMEOUT_EN to enable the WAIT timeout and error counter.
module mult_job_scheduler #(
  parameter int WIDTH       = 10,
  parameter int WIDTH_MLTND = 5,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH_MLTND-1:0] in_a,
  input  logic [WIDTH_MLTND-1:0] in_b,
  output logic [WIDTH-1:0]       mul_data,
  output logic                   mul_enable,
  input  logic                   mul_ready,
  input  logic [WIDTH-1:0]       mul_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_product,
  output logic                   busy,
  output logic                   err_timeout,
  output logic [7:0]             err_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] WAIT    = 2'd2;
  localparam logic [1:0] CAPTURE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [WIDTH-1:0] fifo_d [FIFO_DEPTH];
  logic [WIDTH-1:0] op_q, op_d;
  logic             mul_en_q, mul_en_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_product_q, out_product_d;

  logic fifo_empty, fifo_full, push;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready   = !fifo_full && !rst;
  assign push       = in_valid && in_ready;

`ifdef MULT_JOB_SCHEDULER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_timeout_q, err_timeout_d;
  logic [7:0]       err_count_q, err_count_d;
`endif

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_d        = fifo_q;
    op_d          = op_q;
    mul_en_d      = mul_en_q;
    out_valid_d   = out_valid_q;
    out_product_d = out_product_q;
`ifdef MULT_JOB_SCHEDULER_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    err_timeout_d = 1'b0;
    err_count_d   = err_count_q;
`endif

    if (push) begin
      fifo_d[wr_ptr_q[AW-1:0]] = WIDTH'({in_a, in_b});
      wr_ptr_d = wr_ptr_q + PTR_INC;
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        op_d     = fifo_q[rd_ptr_q[AW-1:0]];
        rd_ptr_d = rd_ptr_q + PTR_INC;
        mul_en_d = 1'b1;
        state_d  = WAIT;
`ifdef MULT_JOB_SCHEDULER_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      WAIT: begin
        if (mul_ready) begin
          mul_en_d = 1'b0;
          state_d  = CAPTURE;
        end
`ifdef MULT_JOB_SCHEDULER_TIMEOUT_EN
        else if (wait_cnt_q == CNT_LAST) begin
          mul_en_d      = 1'b0;
          state_d       = IDLE;
          err_timeout_d = 1'b1;
          if (err_count_q != '1) begin
            err_count_d = err_count_q + 8'd1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_ONE;
        end
`endif
      end
      CAPTURE: begin
        // Loading on the same edge as a consumer accept keeps out_valid high.
        if (!out_valid_q || out_ready) begin
          out_product_d = mul_out;
          out_valid_d   = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      op_q          <= '0;
      mul_en_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      op_q          <= op_d;
      mul_en_q      <= mul_en_d;
      out_valid_q   <= out_valid_d;
      out_product_q <= out_product_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

`ifdef MULT_JOB_SCHEDULER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
      err_count_q   <= '0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      err_timeout_q <= err_timeout_d;
      err_count_q   <= err_count_d;
    end
  end

  assign err_timeout = err_timeout_q;
  assign err_count   = err_count_q;
`else
  assign err_timeout = 1'b0;
  assign err_count   = '0;
`endif

  assign mul_data    = op_q;
  assign mul_enable  = mul_en_q;
  assign out_valid   = out_valid_q;
  assign out_product = out_product_q;
  assign busy        = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mult_job_scheduler.sv
// Self-checking bench for mult_job_scheduler: directed vectors, corner sequences,
// and randomized traffic against a queue-based reference of job order and products.
module tb_mult_job_scheduler;

  localparam int W     = 10;
  localparam int WM    = 5;
  localparam int DEPTH = 4;
  localparam int TO    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [WM-1:0] in_a;
  logic [WM-1:0] in_b;
  logic [W-1:0]  mul_data;
  logic          mul_enable;
  logic          mul_ready;
  logic [W-1:0]  mul_out;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_product;
  logic          busy;
  logic          err_timeout;
  logic [7:0]    err_count;

  always #5 clk = ~clk;

  mult_job_scheduler #(
    .WIDTH(W),
    .WIDTH_MLTND(WM),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .mul_data(mul_data),
    .mul_enable(mul_enable),
    .mul_ready(mul_ready),
    .mul_out(mul_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_product(out_product),
    .busy(busy),
    .err_timeout(err_timeout),
    .err_count(err_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [WM-1:0] a;
    logic [WM-1:0] b;
    logic [W-1:0]  mo;
    logic [W-1:0]  exp_p;
  } vec_t;

  vec_t vecs[8];

  logic [W-1:0] jobq[$];
  logic [W-1:0] expq[$];
  bit           mm_busy = 1'b0;
  int           mm_cnt  = 0;
  logic [W-1:0] mm_res  = '0;
  logic         prev_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Signed product of two operands, wrapped to W bits.
  function automatic logic [W-1:0] ref_prod(input logic [WM-1:0] a, input logic [WM-1:0] b);
    int sa, sb, p;
    sa = $signed(a);
    sb = $signed(b);
    p  = sa * sb;
    return p[W-1:0];
  endfunction

  task automatic push_job(input logic [WM-1:0] a, input logic [WM-1:0] b);
    int k;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      step();
      k++;
    end
    if (!in_ready) check("push_ready_timeout", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_enable(input string name, input logic [W-1:0] exp_data);
    int k;
    k = 0;
    while (!mul_enable && k < 20) begin
      step();
      k++;
    end
    check({name, "_enable"}, mul_enable, 1);
    check({name, "_data"}, mul_data, exp_data);
  endtask

  task automatic finish_mul(input logic [W-1:0] mo);
    mul_ready = 1'b1;
    mul_out   = mo;
    step();
    mul_ready = 1'b0;
  endtask

  task automatic wait_out(input string name, input logic [W-1:0] exp_p);
    int k;
    k = 0;
    while (!out_valid && k < 6) begin
      step();
      k++;
    end
    check({name, "_valid"}, out_valid, 1);
    check({name, "_product"}, out_product, exp_p);
  endtask

  task automatic rand_cycle(input bit allow_push);
    logic push_fire, acc_fire, held_ov;
    logic [W-1:0] held_prod;
    logic [WM-1:0] pa, pb;
    in_valid  = allow_push && ($urandom_range(0, 99) < 60);
    in_a      = WM'($urandom);
    in_b      = WM'($urandom);
    out_ready = allow_push ? ($urandom_range(0, 99) < 70) : 1'b1;
    mul_ready = 1'b0;
    if (mm_busy) begin
      if (mm_cnt == 0) begin
        mul_ready = 1'b1;
        mul_out   = mm_res;
        mm_busy   = 1'b0;
      end else begin
        mm_cnt--;
      end
    end else if (!mul_enable && $urandom_range(0, 19) == 0) begin
      mul_ready = 1'b1;
    end
    push_fire = in_valid && in_ready;
    acc_fire  = out_valid && out_ready;
    held_ov   = out_valid;
    held_prod = out_product;
    pa = in_a;
    pb = in_b;
    step();
    if (push_fire) begin
      jobq.push_back({pa, pb});
      expq.push_back(ref_prod(pa, pb));
    end
    if (acc_fire) begin
      check("rnd_out_expected", expq.size() > 0, 1);
      if (expq.size() > 0) check("rnd_out_product", held_prod, expq.pop_front());
    end else if (held_ov) begin
      check("rnd_hold_valid", out_valid, 1);
      check("rnd_hold_product", out_product, held_prod);
    end
    if (mul_enable && !prev_en) begin
      check("rnd_issue_queued", jobq.size() > 0, 1);
      if (jobq.size() > 0) check("rnd_issue_order", mul_data, jobq.pop_front());
      mm_busy = 1'b1;
      mm_cnt  = $urandom_range(0, 4);
      mm_res  = ref_prod(mul_data[W-1:WM], mul_data[WM-1:0]);
    end
    prev_en = mul_enable;
    check("rnd_in_ready", in_ready, jobq.size() < DEPTH);
    check("rnd_no_timeout", err_timeout, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WM-1:0] ja[6];
    logic [WM-1:0] jb[6];
    int pushed;
    bit fire;
    bit done;

    vecs[0] = '{5'd3,     5'd5,     10'h00F, 10'h00F};
    vecs[1] = '{5'b11110, 5'd7,     10'h3F2, 10'h3F2};
    vecs[2] = '{5'b10000, 5'b10000, 10'h100, 10'h100};
    vecs[3] = '{5'b10000, 5'd15,    10'h310, 10'h310};
    vecs[4] = '{5'd15,    5'd15,    10'h0E1, 10'h0E1};
    vecs[5] = '{5'd0,     5'b11111, 10'h000, 10'h000};
    vecs[6] = '{5'b11111, 5'b11111, 10'h001, 10'h001};
    vecs[7] = '{5'b11111, 5'd1,     10'h3FF, 10'h3FF};

    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    mul_ready = 1'b0;
    mul_out = '0;
    out_ready = 1'b0;
    repeat (3) step();
    check("rst_in_ready_low", in_ready, 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_mul_enable", mul_enable, 0);
    check("rst_mul_data", mul_data, 0);
    check("rst_out_product", out_product, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_err_count", err_count, 0);

    // Directed vectors: mul_ready raised after edge t, out_valid expected after edge t+2.
    for (int i = 0; i < 8; i++) begin
      push_job(vecs[i].a, vecs[i].b);
      wait_enable("vec_issue", {vecs[i].a, vecs[i].b});
      step();
      step();
      check("vec_wait_data", mul_data, {vecs[i].a, vecs[i].b});
      check("vec_wait_enable", mul_enable, 1);
      check("vec_wait_no_out", out_valid, 0);
      finish_mul(vecs[i].mo);
      check("vec_t1_valid", out_valid, 0);
      check("vec_t1_enable", mul_enable, 0);
      step();
      check("vec_t2_valid", out_valid, 1);
      check("vec_product", out_product, vecs[i].exp_p);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("vec_consumed", out_valid, 0);
    end

    // Stray mul_ready while idle must be ignored.
    mul_ready = 1'b1;
    mul_out = 10'h155;
    step();
    mul_ready = 1'b0;
    step();
    check("stray_ready_valid", out_valid, 0);
    check("stray_ready_busy", busy, 0);
    check("stray_ready_enable", mul_enable, 0);

    // Fill: one job in WAIT plus four queued, sixth offer refused.
    for (int i = 0; i < 6; i++) begin
      ja[i] = WM'(i + 1);
      jb[i] = WM'(5'd31 - 5'(3 * i));
    end
    out_ready = 1'b1;
    pushed = 0;
    in_valid = 1'b1;
    in_a = ja[0];
    in_b = jb[0];
    for (int c = 0; c < 12; c++) begin
      fire = in_ready;
      step();
      if (fire) pushed++;
      if (pushed < 6) begin
        in_a = ja[pushed];
        in_b = jb[pushed];
      end
    end
    in_valid = 1'b0;
    check("fill_pushed", pushed, 5);
    check("fill_in_ready", in_ready, 0);
    check("fill_enable", mul_enable, 1);
    check("fill_data", mul_data, {ja[0], jb[0]});
    for (int i = 0; i < 5; i++) begin
      wait_enable("drain_order", {ja[i], jb[i]});
      if (i == 1) check("drain_in_ready", in_ready, 1);
      finish_mul(ref_prod(ja[i], jb[i]));
      wait_out("drain_out", ref_prod(ja[i], jb[i]));
      step();
    end
    check("drain_final_in_ready", in_ready, 1);
    check("drain_final_busy", busy, 0);
    out_ready = 1'b0;

    // Output back-pressure: second result waits in CAPTURE behind the first.
    push_job(5'd6, 5'd7);
    push_job(5'b11101, 5'd9);
    wait_enable("bp_issue_a", {5'd6, 5'd7});
    finish_mul(ref_prod(5'd6, 5'd7));
    wait_out("bp_out_a", ref_prod(5'd6, 5'd7));
    wait_enable("bp_issue_b", {5'b11101, 5'd9});
    finish_mul(ref_prod(5'b11101, 5'd9));
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_product", out_product, ref_prod(5'd6, 5'd7));
      check("bp_hold_busy", busy, 1);
    end
    out_ready = 1'b1;
    step();
    check("bp_second_valid", out_valid, 1);
    check("bp_second_product", out_product, ref_prod(5'b11101, 5'd9));
    step();
    check("bp_second_consumed", out_valid, 0);
    out_ready = 1'b0;

`ifdef MULT_JOB_SCHEDULER_TIMEOUT_EN
    push_job(5'd2, 5'd3);
    wait_enable("to_issue", {5'd2, 5'd3});
    repeat (TO - 1) step();
    check("to_before_pulse", err_timeout, 0);
    check("to_before_enable", mul_enable, 1);
    step();
    check("to_pulse", err_timeout, 1);
    check("to_enable_low", mul_enable, 0);
    check("to_count", err_count, 1);
    check("to_idle", busy, 0);
    step();
    check("to_pulse_end", err_timeout, 0);
    check("to_no_out", out_valid, 0);
    push_job(5'd4, 5'd5);
    wait_enable("to_win_issue", {5'd4, 5'd5});
    repeat (TO - 1) step();
    finish_mul(ref_prod(5'd4, 5'd5));
    check("to_win_no_pulse", err_timeout, 0);
    step();
    check("to_win_valid", out_valid, 1);
    check("to_win_product", out_product, ref_prod(5'd4, 5'd5));
    check("to_win_count", err_count, 1);
`else
    push_job(5'd2, 5'd3);
    wait_enable("to_issue", {5'd2, 5'd3});
    repeat (TO + 8) step();
    check("noto_enable", mul_enable, 1);
    check("noto_busy", busy, 1);
    check("noto_err_timeout", err_timeout, 0);
    check("noto_err_count", err_count, 0);
    finish_mul(ref_prod(5'd2, 5'd3));
    step();
    check("noto_valid", out_valid, 1);
    check("noto_product", out_product, ref_prod(5'd2, 5'd3));
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset during WAIT with queued jobs abandons everything.
    push_job(5'd1, 5'd1);
    push_job(5'd2, 5'd2);
    push_job(5'd3, 5'd3);
    wait_enable("mr_issue", {5'd1, 5'd1});
    check("mr_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("mr_in_ready_in_rst", in_ready, 0);
    step();
    rst = 1'b0;
    #1;
    check("mr_in_ready", in_ready, 1);
    check("mr_out_valid", out_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_enable", mul_enable, 0);
    check("mr_data", mul_data, 0);
    check("mr_product", out_product, 0);
    check("mr_err_count", err_count, 0);
    repeat (4) step();
    check("mr_stays_idle_enable", mul_enable, 0);
    check("mr_stays_idle_busy", busy, 0);
    check("mr_no_out", out_valid, 0);

    prev_en = mul_enable;
    for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
    done = 1'b0;
    for (int c = 0; c < 500 && !done; c++) begin
      rand_cycle(1'b0);
      done = (jobq.size() == 0) && (expq.size() == 0) && !busy && !out_valid && !mm_busy;
    end
    check("rnd_drained", done, 1);
    check("rnd_exp_empty", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_job_scheduler.md
MULT_JOB_SCHEDULER -- requirements
Module: mult_job_scheduler

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; clock port `clk`, reset port `rst`.
REQ-002 Parameters SHALL be, one per line:
- WIDTH, 10, product width and packed multiplier data width.
- WIDTH_MLTND, 5, operand width.
- FIFO_DEPTH, 4, job FIFO entries (power of two).
- TIMEOUT, 32, maximum WAIT cycles.
REQ-003 Ports SHALL be, one per line:
- clk  in  1  clock.
- rst  in  1  sync active-high reset.
- in_valid  in  1  job offered.
- in_ready  out  1  job FIFO can accept.
- in_a  in  WIDTH_MLTND  signed multiplicand.
- in_b  in  WIDTH_MLTND  signed multiplier.
- mul_data  out  WIDTH  {a,b} to the sequential multiplier.
- mul_enable  out  1  multiplier start/run request.
- mul_ready  in  1  multiplier done pulse.
- mul_out  in  WIDTH  multiplier result register.
- out_valid  out  1  product available.
- out_ready  in  1  consumer accepts.
- out_product  out  WIDTH  signed product.
- busy  out  1  state != IDLE or FIFO non-empty.
- err_timeout  out  1  one-cycle timeout pulse.
- err_count  out  8  saturating timeout count.

Function
REQ-004 A job SHALL be pushed when in_valid && in_ready; in_ready SHALL be !full, and 0 while rst=1.
REQ-005 The FIFO SHALL have no bypass: a job pushed at edge t is poppable no earlier than edge t+1; pointers wrap modulo FIFO_DEPTH.
REQ-006 The FSM SHALL have states IDLE, ISSUE, WAIT and CAPTURE.
REQ-007 IDLE SHALL go to ISSUE when the FIFO is non-empty, otherwise it SHALL remain in IDLE.
REQ-008 ISSUE SHALL pop the FIFO head into the operand register, assert mul_enable, and go to WAIT next cycle.
REQ-009 mul_data SHALL equal {op_a, op_b}, held stable from ISSUE until CAPTURE exits.
REQ-010 WAIT SHALL keep mul_enable=1; on mul_ready=1 it SHALL go to CAPTURE with mul_enable=0 from that edge.
REQ-011 In CAPTURE, if !out_valid || out_ready, the block SHALL load out_product <= mul_out, set out_valid=1 and go to IDLE; otherwise it SHALL stay in CAPTURE.
REQ-012 out_valid SHALL hold with out_product stable until out_valid && out_ready; it SHALL clear on that edge unless reloaded in the same edge.
REQ-013 Latency SHALL be: mul_ready at edge t gives out_valid at edge t+2 when the output slot is free.
REQ-014 Products SHALL be passed through unmodified as WIDTH-bit two's complement; no sign extension or truncation.
REQ-015 A simultaneous push on a full FIFO SHALL be impossible, since in_ready=0.
REQ-016 A push and an ISSUE pop in the same cycle SHALL both take effect.
REQ-017 mul_ready outside WAIT SHALL be ignored.

Reset
REQ-018 On rst=1 at an edge, the block SHALL set state=IDLE and empty the FIFO.
REQ-019 On the same edge it SHALL clear the operand register and out_product, and set out_valid=0, mul_enable=0, mul_data=0, err_timeout=0 and err_count=0.
REQ-020 busy SHALL be 0 after reset.
REQ-021 Reset mid-operation SHALL abandon the in-flight job and all queued jobs with no output produced.

Configuration
REQ-022 With macro MULT_JOB_SCHEDULER_TIMEOUT_EN defined, a WAIT cycle counter SHALL run.
REQ-023 With the macro defined, on the TIMEOUT-th consecutive WAIT cycle without mul_ready, the FSM SHALL return to IDLE with mul_enable=0.
REQ-024 On that timeout the job SHALL be dropped, err_timeout SHALL pulse for one cycle, and err_count SHALL increment, saturating at 255.
REQ-025 If mul_ready arrives on the TIMEOUT-th cycle, completion SHALL win.
REQ-026 Without the macro, WAIT SHALL wait indefinitely, and err_timeout and err_count SHALL be tied to 0.

Verification
REQ-027 Push a=5'd3, b=5'd5, model returns mul_ready then mul_out=10'h00F -> out_product=10'h00F, out_valid two edges after mul_ready.
REQ-028 Push a=5'b11110 (-2), b=5'd7, mul_out=10'h3F2 -> out_product=10'h3F2 (-14); mul_data=10'b11110_00111 throughout WAIT.
REQ-029 Hold mul_ready=0 and offer 6 jobs -> 1 issued and 4 queued, then in_ready=0; draining restores in_ready=1 with jobs issued in push order.
REQ-030 out_ready=0 with two back-to-back jobs -> second job holds in CAPTURE, first product stays stable until out_ready=1, then second appears next edge.
REQ-031 With the macro defined and TIMEOUT=32, withhold mul_ready -> err_timeout pulses on the 32nd WAIT cycle, err_count=1, FSM reaches IDLE; without the macro the FSM stays in WAIT.
REQ-032 Assert rst for one cycle during WAIT with 2 jobs queued -> next cycle in state IDLE, in_ready=1, out_valid=0, busy=0, mul_enable=0.
